// File: rtl/trans_sched_if.sv
// Requester lanes plus transmitter-side beat outputs of the round-robin scheduler.
// slave = scheduler view, master = requesters/transmitter view.
interface trans_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int GW = $clog2(NREQ);

  // Handshake: a beat on lane i transfers on a rising clk edge where req_vld[i] & req_rdy[i];
  // req_rdy depends only on scheduler state, never on req_vld.
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_byt;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_rdy;
  logic               tx_start;
  logic [DW-1:0]      tx_data;
  logic               tx_byt;
  logic [GW-1:0]      gnt_id;
  logic               busy;
  logic               trunc;

  modport slave (
    input  req_vld, req_data, req_byt, req_last,
    output req_rdy, tx_start, tx_data, tx_byt, gnt_id, busy, trunc
  );

  modport master (
    output req_vld, req_data, req_byt, req_last,
    input  req_rdy, tx_start, tx_data, tx_byt, gnt_id, busy, trunc
  );
endinterface

// File: rtl/trans_sched.sv
// Round-robin burst scheduler feeding the byte transmitter (IDLE -> XFER -> GAP).
// Optional TRANS_SCHED_PRIO_EN: requester 0 gets fixed priority over the round robin.
module trans_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  trans_sched_if.slave bus,
  output logic [1:0]   state_dbg
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, rr_nxt, gnt_id, win_id;
  logic [GW:0]     arb_sum;
  logic            win_ok;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   lane_data;
  logic            lane_vld, lane_byt, lane_last;
  logic            accept, cap_hit, burst_end;
  logic [NREQ-1:0] rdy;
  logic            tx_start_q, tx_byt_q, trunc_q;
  logic [DW-1:0]   tx_data_q;

  // Scan from highest offset down so the lowest offset from rr_ptr is the final winner.
  always_comb begin
    win_id  = '0;
    win_ok  = 1'b0;
    arb_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (arb_sum >= (GW+1)'(NREQ)) arb_sum = arb_sum - (GW+1)'(NREQ);
      if (bus.req_vld[arb_sum[GW-1:0]]) begin
        win_id = arb_sum[GW-1:0];
        win_ok = 1'b1;
      end
    end
`ifdef TRANS_SCHED_PRIO_EN
    if (bus.req_vld[0]) win_id = '0;
`endif
  end

  always_comb begin
    lane_data = '0;
    lane_vld  = 1'b0;
    lane_byt  = 1'b0;
    lane_last = 1'b0;
    rdy       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == GW'(i)) begin
        lane_data = bus.req_data[i*DW +: DW];
        lane_vld  = bus.req_vld[i];
        lane_byt  = bus.req_byt[i];
        lane_last = bus.req_last[i];
        rdy[i]    = (state == XFER);
      end
    end
  end

  assign accept    = (state == XFER) && lane_vld;
  assign cap_hit   = (cnt == CW'(MAX_BURST - 1));
  assign burst_end = accept && (lane_last || cap_hit);

  always_comb begin
    rr_nxt = (gnt_id == GW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef TRANS_SCHED_PRIO_EN
    if (gnt_id == '0) rr_nxt = rr_ptr;
`endif
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_ok) state_nxt = XFER;
      XFER:    if (burst_end) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      gnt_id <= '0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && win_ok) begin
        gnt_id <= win_id;
        cnt    <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (state == GAP) rr_ptr <= rr_nxt;
    end
  end

  // Beat data and flag hold their last value when no beat is forwarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_byt_q   <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      tx_start_q <= accept;
      trunc_q    <= accept && cap_hit && !lane_last;
      if (accept) begin
        tx_data_q <= lane_data;
        tx_byt_q  <= lane_byt;
      end
    end
  end

  assign bus.req_rdy  = rdy;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_byt   = tx_byt_q;
  assign bus.gnt_id   = gnt_id;
  assign bus.busy     = (state != IDLE);
  assign bus.trunc    = trunc_q;
  assign state_dbg    = state;

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rdy));
  a_gap_one_cycle: assert property (@(posedge clk) disable iff (!reset_n)
    (state == GAP) |=> (state == IDLE));
  a_trunc_with_beat: assert property (@(posedge clk) disable iff (!reset_n)
    trunc_q |-> tx_start_q);
endmodule
